// File: rtl/uart_line_scheduler.sv
// rtl/uart_line_scheduler.sv - per-core byte FIFOs feeding one UART, whole lines granted round-robin; optional idle flush under UART_SCHED_TIMEOUT_EN
module uart_line_scheduler #(
  parameter int CORE_NUMS      = 4,
  parameter int CORE_NUMS_BITS = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT        = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [CORE_NUMS-1:0]        core_wr_i,
  input  logic [8*CORE_NUMS-1:0]      core_data_i,
  output logic [CORE_NUMS-1:0]        core_full_o,
  output logic [CORE_NUMS-1:0]        core_ovf_o,
  output logic                        tx_valid_o,
  output logic [7:0]                  tx_data_o,
  input  logic                        tx_ready_i,
  output logic [CORE_NUMS_BITS-1:0]   owner_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SEND} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [7:0]                r_mem    [CORE_NUMS][FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr [CORE_NUMS];
  logic [PTR_W-1:0]          r_rd_ptr [CORE_NUMS];
  logic [CNT_W-1:0]          r_count  [CORE_NUMS];
  logic [CNT_W-1:0]          r_line   [CORE_NUMS];
  logic [CORE_NUMS-1:0]      r_ovf;
  logic [CORE_NUMS_BITS-1:0] r_owner;
  logic [7:0]                r_tx_data;

  logic [CORE_NUMS-1:0]      w_accept;
  logic [CORE_NUMS-1:0]      w_pop;
  logic [CORE_NUMS-1:0]      w_elig;
  logic [CORE_NUMS-1:0]      w_to_hit;
  logic                      w_found;
  logic [CORE_NUMS_BITS-1:0] w_pick;
  logic                      w_xfer;
  logic                      w_last;
  logic                      w_grant;
  logic                      w_load;
  logic                      w_advance;
  logic [7:0]                w_head;
  logic [7:0]                w_next;
  logic [PTR_W-1:0]          w_rd_next;

  assign tx_data_o  = r_tx_data;
  assign owner_o    = r_owner;
  assign core_ovf_o = r_ovf;

  // head byte of the granted FIFO and the byte behind it, for back-to-back sending
  assign w_head    = r_mem[r_owner][r_rd_ptr[r_owner]];
  assign w_rd_next = r_rd_ptr[r_owner] + PTR_W'(1);
  assign w_next    = r_mem[r_owner][w_rd_next];

  // per-core full, write acceptance (on registered count), pop and eligibility
  always_comb begin
    core_full_o = '0;
    w_accept    = '0;
    w_pop       = '0;
    w_elig      = '0;
    for (int k = 0; k < CORE_NUMS; k++) begin
      core_full_o[k] = (r_count[k] == CNT_W'(FIFO_DEPTH));
      w_accept[k]    = core_wr_i[k] && !core_full_o[k];
      w_pop[k]       = w_xfer && (r_owner == CORE_NUMS_BITS'(k));
      w_elig[k]      = (r_line[k] != '0) || core_full_o[k] || w_to_hit[k];
    end
  end

  // round-robin search starting at the core after the last owner
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_owner;
    for (int i = 1; i <= CORE_NUMS; i++) begin
      if (!w_found && w_elig[(int'(r_owner) + i) % CORE_NUMS]) begin
        w_found = 1'b1;
        w_pick  = CORE_NUMS_BITS'((int'(r_owner) + i) % CORE_NUMS);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: a grant holds until a newline or an empty FIFO ends it
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_SEND;
      S_SEND:  if (w_xfer && w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and datapath controls
  always_comb begin
    tx_valid_o = (r_state == S_SEND);
    w_xfer     = tx_valid_o && tx_ready_i;
    w_last     = (r_tx_data == 8'h0A) || (r_count[r_owner] == CNT_W'(1));
    w_grant    = (r_state == S_IDLE) && w_found;
    w_load     = (r_state == S_GRANT);
    w_advance  = w_xfer && !w_last;
  end

  // owner and offered byte; the byte only changes on load or after a transfer
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_owner   <= CORE_NUMS_BITS'(CORE_NUMS - 1);
      r_tx_data <= 8'h00;
    end else begin
      if (w_grant) r_owner <= w_pick;
      if (w_load)         r_tx_data <= w_head;
      else if (w_advance) r_tx_data <= w_next;
    end
  end

  // FIFO storage, left unreset; pointers and counts define its contents
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CORE_NUMS; k++) begin
      if (w_accept[k]) r_mem[k][r_wr_ptr[k]] <= core_data_i[8*k +: 8];
    end
  end

  // FIFO pointers, occupancy, newline counts and sticky overflow
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CORE_NUMS; k++) begin
      if (!rst_ni) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
        r_line[k]   <= '0;
        r_ovf[k]    <= 1'b0;
      end else begin
        if (w_accept[k]) r_wr_ptr[k] <= r_wr_ptr[k] + PTR_W'(1);
        if (w_pop[k])    r_rd_ptr[k] <= r_rd_ptr[k] + PTR_W'(1);
        case ({w_accept[k], w_pop[k]})
          2'b10:   r_count[k] <= r_count[k] + CNT_W'(1);
          2'b01:   r_count[k] <= r_count[k] - CNT_W'(1);
          default: r_count[k] <= r_count[k];
        endcase
        case ({w_accept[k] && (core_data_i[8*k +: 8] == 8'h0A),
               w_pop[k] && (r_tx_data == 8'h0A)})
          2'b10:   r_line[k] <= r_line[k] + CNT_W'(1);
          2'b01:   r_line[k] <= r_line[k] - CNT_W'(1);
          default: r_line[k] <= r_line[k];
        endcase
        if (core_wr_i[k] && core_full_o[k]) r_ovf[k] <= 1'b1;
      end
    end
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] r_to_cnt [CORE_NUMS];

  // idle-partial-line timers; saturate at TIMEOUT, cleared by a write or a grant
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < CORE_NUMS; k++) begin
      if (!rst_ni) begin
        r_to_cnt[k] <= '0;
      end else if (core_wr_i[k] || (w_grant && (w_pick == CORE_NUMS_BITS'(k))) ||
                   (r_count[k] == '0) || (r_line[k] != '0)) begin
        r_to_cnt[k] <= '0;
      end else if (r_to_cnt[k] != TO_W'(TIMEOUT)) begin
        r_to_cnt[k] <= r_to_cnt[k] + TO_W'(1);
      end
    end
  end

  // a saturated timer makes the partial line eligible for flushing
  always_comb begin
    w_to_hit = '0;
    for (int k = 0; k < CORE_NUMS; k++) begin
      w_to_hit[k] = (r_to_cnt[k] == TO_W'(TIMEOUT));
    end
  end
`else
  assign w_to_hit = '0;
`endif

endmodule

// File: tb/tb_uart_line_scheduler.sv
// tb/tb_uart_line_scheduler.sv - directed self-checking bench for uart_line_scheduler
module tb_uart_line_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [3:0]  core_wr_i;
  logic [31:0] core_data_i;
  logic [3:0]  core_full_o;
  logic [3:0]  core_ovf_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic [1:0]  owner_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_line_scheduler #(
    .CORE_NUMS(4), .CORE_NUMS_BITS(2), .FIFO_DEPTH(16), .TIMEOUT(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .core_wr_i(core_wr_i), .core_data_i(core_data_i),
    .core_full_o(core_full_o), .core_ovf_o(core_ovf_o), .tx_valid_o(tx_valid_o),
    .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic tx_expect(input string tag, input logic v, input logic [7:0] d);
    check({tag, ".valid"}, 32'(tx_valid_o), 32'(v));
    if (v) check({tag, ".data"}, 32'(tx_data_o), 32'(d));
  endtask

  task automatic put(input int c, input logic [7:0] b);
    core_wr_i = '0;
    core_data_i = '0;
    core_wr_i[c] = 1'b1;
    core_data_i[8*c +: 8] = b;
    step();
    core_wr_i = '0;
  endtask

  task automatic put2(input logic [7:0] b0, input logic [7:0] b2);
    core_wr_i = 4'b0101;
    core_data_i = {8'h00, b2, 8'h00, b0};
    step();
    core_wr_i = '0;
  endtask

  initial begin
    int first;
    int seen;
    rst_ni = 1'b0;
    core_wr_i = '0;
    core_data_i = '0;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    step();
    step();
    tx_expect("rst", 1'b0, 8'h00);
    check("rst.owner", 32'(owner_o), 32'd3);
    check("rst.full", 32'(core_full_o), 32'h0);
    check("rst.ovf", 32'(core_ovf_o), 32'h0);
    check("rst.data", 32'(tx_data_o), 32'h0);
    rst_ni = 1'b1;

    // core 1 sends "hi\n"
    put(1, 8'h68);
    put(1, 8'h69);
    put(1, 8'h0A);
    tx_expect("hi.c0", 1'b0, 8'h00);
    step();
    tx_expect("hi.c1", 1'b0, 8'h00);
    check("hi.owner", 32'(owner_o), 32'd1);
    step(); tx_expect("hi.b0", 1'b1, 8'h68);
    step(); tx_expect("hi.b1", 1'b1, 8'h69);
    step(); tx_expect("hi.b2", 1'b1, 8'h0A);
    step(); tx_expect("hi.end", 1'b0, 8'h00);

    // simultaneous lines from cores 0 and 2 after reset
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check("rr.rst_owner", 32'(owner_o), 32'd3);
    put2(8'h41, 8'h42);
    put2(8'h0A, 8'h0A);
    tx_expect("rr1.c0", 1'b0, 8'h00);
    step(); check("rr1.owner0", 32'(owner_o), 32'd0);
    step(); tx_expect("rr1.a0", 1'b1, 8'h41);
    step(); tx_expect("rr1.a1", 1'b1, 8'h0A);
    step(); tx_expect("rr1.gap", 1'b0, 8'h00);
    step(); check("rr1.owner2", 32'(owner_o), 32'd2);
    step(); tx_expect("rr1.b0", 1'b1, 8'h42);
    step(); tx_expect("rr1.b1", 1'b1, 8'h0A);
    step(); tx_expect("rr1.end", 1'b0, 8'h00);
    put2(8'h43, 8'h44);
    put2(8'h0A, 8'h0A);
    step(); check("rr2.owner0", 32'(owner_o), 32'd0);
    step(); tx_expect("rr2.a0", 1'b1, 8'h43);
    step(); tx_expect("rr2.a1", 1'b1, 8'h0A);
    step(); tx_expect("rr2.gap", 1'b0, 8'h00);
    step(); check("rr2.owner2", 32'(owner_o), 32'd2);
    step(); tx_expect("rr2.b0", 1'b1, 8'h44);
    step(); tx_expect("rr2.b1", 1'b1, 8'h0A);
    step(); tx_expect("rr2.end", 1'b0, 8'h00);

    // core 3 overfills without a newline while the transmitter stalls
    tx_ready_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      put(3, 8'(8'h30 + i));
      if (i == 14) check("full.before", 32'(core_full_o), 32'h0);
      if (i == 15) check("full.at16", 32'(core_full_o), 32'h8);
    end
    check("full.after17", 32'(core_full_o), 32'h8);
    check("ovf.set", 32'(core_ovf_o), 32'h8);
    step();
    check("full.owner", 32'(owner_o), 32'd3);
    for (int i = 0; i < 5; i++) begin
      tx_expect("stall", 1'b1, 8'h30);
      step();
    end
    check("stall.nopop", 32'(core_full_o), 32'h8);
    for (int j = 0; j < 16; j++) begin
      tx_expect("flush", 1'b1, 8'(8'h30 + j));
      tx_ready_i = 1'b1;
      step();
    end
    tx_expect("flush.end", 1'b0, 8'h00);
    check("flush.full", 32'(core_full_o), 32'h0);
    check("ovf.sticky", 32'(core_ovf_o), 32'h8);

    // reset in the middle of a line discards everything
    tx_ready_i = 1'b0;
    put(1, 8'h78);
    put(1, 8'h79);
    put(1, 8'h0A);
    step();
    step();
    tx_expect("mid.b0", 1'b1, 8'h78);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    tx_expect("mid.rst", 1'b0, 8'h00);
    check("mid.owner", 32'(owner_o), 32'd3);
    check("mid.ovf", 32'(core_ovf_o), 32'h0);
    tx_ready_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tx_valid_o) seen++;
    end
    check("mid.empty", 32'(seen), 32'd0);
    put(1, 8'h7A);
    put(1, 8'h0A);
    step();
    step(); tx_expect("mid.new0", 1'b1, 8'h7A);
    step(); tx_expect("mid.new1", 1'b1, 8'h0A);
    step(); tx_expect("mid.new_end", 1'b0, 8'h00);

    // a lone byte without newline: flushed only by the idle timeout
    put(0, 8'h41);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tx_valid_o && first == 0) begin
        first = k;
        check("to.data", 32'(tx_data_o), 32'h41);
      end
    end
`ifdef UART_SCHED_TIMEOUT_EN
    check("to.latency", 32'(first), 32'd10);
`else
    check("to.never", 32'(first), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_line_scheduler.md
UART_LINE_SCHEDULER -- requirements
Module: uart_line_scheduler

Interface
REQ-001 SHALL have parameter CORE_NUMS, default 4: number of requesting cores.
REQ-002 SHALL have parameter CORE_NUMS_BITS, default 2: width of core index.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: bytes per core FIFO, power of two.
REQ-004 SHALL have parameter TIMEOUT, default 1024: idle-flush cycle count (see REQ-027).
REQ-005 SHALL have port clk_i, input, 1: single clock, all logic rising-edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port core_wr_i, input, CORE_NUMS: per-core byte write strobe.
REQ-008 SHALL have port core_data_i, input, 8*CORE_NUMS: core k byte at [8k+7:8k].
REQ-009 SHALL have port core_full_o, output, CORE_NUMS: core k FIFO full.
REQ-010 SHALL have port core_ovf_o, output, CORE_NUMS: sticky dropped-write flag.
REQ-011 SHALL have port tx_valid_o, output, 1: byte offered to UART transmitter.
REQ-012 SHALL have port tx_data_o, output, 8: offered byte.
REQ-013 SHALL have port tx_ready_i, input, 1: transmitter accepts byte.
REQ-014 SHALL have port owner_o, output, CORE_NUMS_BITS: core currently or last granted.

Function
REQ-015 SHALL accept a write to core k FIFO when core_wr_i[k]=1 and count_k<FIFO_DEPTH, judged on the registered count; when full, the write is dropped and core_ovf_o[k] is set, even if a pop occurs that cycle.
REQ-016 SHALL drive core_full_o[k]=1 exactly when count_k==FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL keep per-core line count: +1 on accepted 0x0A write, -1 on popped 0x0A, unchanged if both occur in one cycle.
REQ-018 SHALL mark core k eligible when line_count_k>0 or core_full_o[k]=1.
REQ-019 SHALL use FSM states S_IDLE, S_GRANT, S_SEND.
REQ-020 S_IDLE -> S_GRANT when any core is eligible; grant is round-robin, searching from owner_o+1 with wrap, and owner_o is updated.
REQ-021 S_GRANT -> S_SEND after one cycle; the FIFO head is loaded into tx_data_o and tx_valid_o=1 on entering S_SEND, giving 2 cycles from eligibility to the first valid.
REQ-022 In S_SEND, transfer occurs when tx_valid_o & tx_ready_i; tx_data_o SHALL stay stable while tx_valid_o=1 and tx_ready_i=0.
REQ-023 After a transfer of 0x0A, or a transfer that empties the granted FIFO, SHALL deassert tx_valid_o next cycle and return to S_IDLE; otherwise present the next byte in the cycle after the transfer (back-to-back).
REQ-024 Bytes of one granted line SHALL never interleave with another core's bytes.
REQ-025 Writes to the granted core during S_SEND SHALL be accepted normally.
REQ-026 core_ovf_o[k] SHALL clear only on reset.

Configuration
REQ-027 With macro UART_SCHED_TIMEOUT_EN defined, a per-core counter SHALL count cycles with count_k>0, line_count_k==0 and no accepted write; at TIMEOUT the core becomes eligible, the counter resets on any write or grant, and the partial line is flushed until the FIFO is empty.
REQ-028 Without UART_SCHED_TIMEOUT_EN, no timeout counters SHALL exist and eligibility is REQ-018 only.

Reset
REQ-029 While rst_ni=0 at a rising edge: state=S_IDLE, all FIFO pointers, counts and line counts=0, tx_valid_o=0, tx_data_o=0, owner_o=CORE_NUMS-1 (core 0 searched first), core_full_o=0, core_ovf_o=0, timeout counters=0.
REQ-030 Reset asserted mid-S_SEND SHALL abandon the transfer and discard all buffered bytes.

Verification
REQ-031 Core 1 writes "hi\n" (0x68,0x69,0x0A), tx_ready_i=1 -> tx_valid_o rises 2 cycles after the 0x0A write; 0x68,0x69,0x0A on consecutive cycles; owner_o=1.
REQ-032 Cores 0 and 2 each complete a line in the same cycle -> core 0 line sent whole, then core 2; next simultaneous lines from 0 and 2 -> core 2 first is wrong, order continues from owner 2 -> core 0.
REQ-033 Core 3 writes 17 bytes without 0x0A, tx_ready_i=0 -> core_full_o[3]=1 after 16, core_ovf_o[3]=1; with ready=1, 16 bytes flushed then S_IDLE.
REQ-034 tx_ready_i held 0 for 5 cycles during S_SEND -> tx_data_o unchanged, no pop.
REQ-035 With UART_SCHED_TIMEOUT_EN and TIMEOUT=8, core 0 writes 0x41 only -> 0x41 offered 8+2 cycles after the write; without the macro, never offered.
REQ-036 rst_ni=0 for one cycle mid-line -> tx_valid_o=0 next cycle, all FIFOs empty, owner_o=CORE_NUMS-1.
